// File: rtl/lowrisc_rx_buf_ctrl.sv
// Receive buffer controller. It packs an unstallable byte stream into 64-bit
// buffer RAM words and keeps a ring of NBUF frame buffers. Committed frames
// are handed to software oldest-first, with their lengths.
module lowrisc_rx_buf_ctrl #(
  parameter int NBUF      = 4,
  parameter int BUF_WORDS = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        s_tdata,
  input  logic                              s_tvalid,
  input  logic                              s_tlast,
  input  logic                              s_tuser,
  output logic                              mem_we,
  output logic [$clog2(NBUF*BUF_WORDS)-1:0] mem_addr,
  output logic [63:0]                       mem_wdata,
  output logic [7:0]                        mem_wstrb,
  output logic                              rx_avail,
  output logic [$clog2(NBUF)-1:0]           rx_buf,
  output logic [15:0]                       rx_len,
  input  logic                              rx_pop,
  output logic [15:0]                       drop_cnt
);
  localparam int          BW      = $clog2(NBUF);
  localparam int          OW      = $clog2(BUF_WORDS);
  localparam logic [16:0] CAP     = 17'(BUF_WORDS * 8);
  localparam logic [15:0] MIN_LEN = 16'd14;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t        state_q, state_d;
  logic          resync_q, resync_d;
  logic [15:0]   cnt_q;
  logic [63:0]   pack_q;
  logic [7:0]    strb_q;
  logic [BW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, wr_buf;
  logic [BW:0]   used_q, used_d;
  logic          commit_q;
  logic [15:0]   commit_len_q;
  logic [15:0]   len_tab_q [NBUF];

  logic          space, take, overflow, accept, flush, good_end, drop_evt, pop;
  logic [15:0]   base, len;
  logic [2:0]    lane;
  logic [63:0]   word_d;
  logic [7:0]    strb_d;

  // Per-beat decode. A commit still in flight already owns its buffer, so
  // it counts as used, and a frame starting right behind it targets the
  // next buffer.
  always_comb begin
    wr_buf   = wr_ptr_q + BW'(commit_q);
    space    = (used_q + (BW+1)'(commit_q)) < (BW+1)'(NBUF);
    take     = s_tvalid && ((state_q == RECV) ||
                            (state_q == IDLE && !resync_q && space));
    base     = (state_q == RECV) ? cnt_q : 16'd0;
    len      = base + 16'd1;
    lane     = base[2:0];
    overflow = take && ({1'b0, base} == CAP);
    accept   = take && !overflow;
    word_d   = ((state_q == RECV) ? pack_q : 64'd0) | (64'(s_tdata) << {lane, 3'b000});
    strb_d   = ((state_q == RECV) ? strb_q : 8'd0) | (8'd1 << lane);
    flush    = accept && (lane == 3'd7 || s_tlast);
    good_end = accept && s_tlast && !s_tuser && (len >= MIN_LEN);
    // Every frame end that is not a commit is a drop. The exception is the
    // tail of a frame cut short by reset.
    drop_evt = s_tvalid && s_tlast && !resync_q && !good_end;
    pop      = rx_pop && rx_avail;
    rd_ptr_d = rd_ptr_q + BW'(pop);
    used_d   = used_q + (BW+1)'(commit_q) - (BW+1)'(pop);
  end

  // Next-state logic. Out of reset, a stream that is already mid-frame
  // (valid with no idle cycle seen yet) is skipped up to its last byte.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    resync_d = resync_q;
    if (s_tvalid && s_tlast)                resync_d = 1'b0;
    else if (state_q == IDLE && !s_tvalid)  resync_d = 1'b0;
    case (state_q)
      IDLE:    if (s_tvalid && !s_tlast) state_d = take ? RECV : DROP;
      RECV:    if (s_tvalid) begin
                 if (s_tlast)       state_d = IDLE;
                 else if (overflow) state_d = DROP;
               end
      DROP:    if (s_tvalid && s_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and resync flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      resync_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      resync_q <= resync_d;
    end
  end

  // Byte counter and word packing register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pack_q <= '0;
      strb_q <= '0;
    end else if (accept) begin
      cnt_q  <= len;
      pack_q <= flush ? 64'd0 : word_d;
      strb_q <= flush ? 8'd0  : strb_d;
    end
  end

  // Buffer RAM write port. A write is issued one cycle after the beat that
  // completes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= flush;
      if (flush) begin
        mem_addr  <= {wr_buf, base[OW+2:3]};
        mem_wdata <= word_d;
        mem_wstrb <= strb_d;
      end
    end
  end

  // Commit is delayed by one cycle so the descriptor lands after the final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q     <= 1'b0;
      commit_len_q <= '0;
      drop_cnt     <= '0;
    end else begin
      commit_q <= good_end;
      if (good_end) commit_len_q <= len;
      if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Buffer ring pointers, occupancy and frame length table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      // NOTE: the small length table is reset so rx_len is a defined 0 out of reset instead of X.
      for (int i = 0; i < NBUF; i++) len_tab_q[i] <= '0;
    end else begin
      if (commit_q) begin
        len_tab_q[wr_ptr_q] <= commit_len_q;
        wr_ptr_q            <= wr_ptr_q + BW'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // Registered software view of the oldest frame. A commit in the same cycle
  // bypasses the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_avail <= 1'b0;
      rx_buf   <= '0;
      rx_len   <= '0;
    end else begin
      rx_avail <= (used_d != '0);
      rx_buf   <= rd_ptr_d;
      rx_len   <= (commit_q && rd_ptr_d == wr_ptr_q) ? commit_len_q : len_tab_q[rd_ptr_d];
    end
  end
endmodule

// File: tb/tb_lowrisc_rx_buf_ctrl.sv
// Testbench for lowrisc_rx_buf_ctrl. It drives directed and random frames.
// A frame-level model predicts the RAM writes into a queue that a monitor
// drains. The software-visible descriptors and the drop count are compared
// every cycle.
module tb_lowrisc_rx_buf_ctrl;
  localparam int NBUF      = 4;
  localparam int BUF_WORDS = 256;
  localparam int AW        = $clog2(NBUF * BUF_WORDS);
  localparam int BW        = $clog2(NBUF);
  localparam int CAP       = BUF_WORDS * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, rx_pop = 1'b0;
  logic          mem_we, rx_avail;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_wstrb;
  logic [BW-1:0] rx_buf;
  logic [15:0]   rx_len, drop_cnt;

  always #5 clk = ~clk;

  lowrisc_rx_buf_ctrl #(.NBUF(NBUF), .BUF_WORDS(BUF_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .rx_avail(rx_avail), .rx_buf(rx_buf), .rx_len(rx_len), .rx_pop(rx_pop),
    .drop_cnt(drop_cnt)
  );

  typedef struct { int buf_idx; int len; int vis; } desc_t;
  typedef struct { int addr; logic [63:0] data; logic [7:0] strb; } wr_t;
  typedef enum { M_NONE, M_TAKE, M_TOSS, M_QUIET } mode_t;

  desc_t       desc_q[$];  // committed frames, oldest first, with first visible cycle
  wr_t         wr_q[$];    // expected RAM writes
  int          n_vec = 0, n_bad = 0, cyc = 0, pop_pct = 0;
  mode_t       m_mode = M_NONE;
  bit          m_after_reset = 1'b1;
  int          m_idx = 0, m_buf = 0, m_wr_ptr = 0, m_drop = 0;
  logic [63:0] m_word = '0;
  logic [7:0]  m_strb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM write must match the next predicted one.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        wr_t         e;
        logic [63:0] mask;
        e = wr_q.pop_front();
        mask = '0;
        for (int k = 0; k < 8; k++) if (e.strb[k]) mask[k*8 +: 8] = 8'hFF;
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_strb", 64'(mem_wstrb), 64'(e.strb));
        check("wr_data", mem_wdata & mask, e.data & mask);
      end
    end
  end

  // Frame-level reference for the edge that samples these inputs. A frame
  // either owns the next free buffer or is thrown away. Bytes beyond the
  // buffer capacity abort it. It commits only if it is good and at least
  // 14 bytes long. A commit becomes visible two cycles after its last byte.
  task automatic model_edge(input bit v, input logic [7:0] d, input bit l, input bit u, input bit p);
    int lane;
    if (v) begin
      if (m_mode == M_NONE) begin
        if (m_after_reset)            m_mode = M_QUIET;
        else if (desc_q.size() < NBUF) begin
          m_mode = M_TAKE; m_idx = 0; m_buf = m_wr_ptr; m_word = '0; m_strb = '0;
        end else                      m_mode = M_TOSS;
      end
      if (m_mode == M_TAKE && m_idx == CAP) m_mode = M_TOSS;
      if (m_mode == M_TAKE) begin
        lane = m_idx % 8;
        m_word[lane*8 +: 8] = d;
        m_strb[lane] = 1'b1;
        if (lane == 7 || l) begin
          wr_q.push_back('{m_buf * BUF_WORDS + m_idx / 8, m_word, m_strb});
          m_word = '0; m_strb = '0;
        end
        m_idx++;
        if (l) begin
          if (!u && m_idx >= 14) begin
            desc_q.push_back('{m_buf, m_idx, cyc + 2});
            m_wr_ptr = (m_wr_ptr + 1) % NBUF;
          end else if (m_drop < 65535) m_drop++;
          m_mode = M_NONE;
        end
      end else if (m_mode == M_TOSS) begin
        if (l) begin
          if (m_drop < 65535) m_drop++;
          m_mode = M_NONE;
        end
      end else if (l) begin
        m_mode = M_NONE;
        m_after_reset = 1'b0;
      end
    end else if (m_mode == M_NONE) m_after_reset = 1'b0;
    if (p && desc_q.size() != 0)
      if (desc_q[0].vis <= cyc) void'(desc_q.pop_front());
  endtask

  // One clock cycle: compare the visible outputs, drive the inputs, update the model.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit u, input bit p);
    bit exp_av;
    exp_av = 1'b0;
    if (desc_q.size() != 0) exp_av = (desc_q[0].vis <= cyc);
    check("rx_avail", 64'(rx_avail), 64'(exp_av));
    if (exp_av) begin
      check("rx_buf", 64'(rx_buf), 64'(desc_q[0].buf_idx));
      check("rx_len", 64'(rx_len), 64'(desc_q[0].len));
    end
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u; rx_pop = p;
    model_edge(v, d, l, u, p);
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic bit rand_pop();
    return $urandom_range(99) < pop_pct;
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, rand_pop());
  endtask

  task automatic pop_all();
    repeat (24) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input int len, input bit bad, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      int g;
      bit last;
      g = 0;
      while (gap_pct > 0 && g < 4 && $urandom_range(99) < gap_pct) begin
        step(1'b0, 8'h00, 1'b0, 1'b0, rand_pop());
        g++;
      end
      last = (i == len - 1);
      step(1'b1, 8'($urandom), last, last ? bad : 1'($urandom), rand_pop());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0; rx_pop = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_rx_avail", 64'(rx_avail), 64'd0);
    check("rst_rx_buf", 64'(rx_buf), 64'd0);
    check("rst_rx_len", 64'(rx_len), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    wr_q.delete();
    desc_q.delete();
    m_mode = M_NONE; m_after_reset = 1'b1; m_wr_ptr = 0; m_drop = 0;
    m_idx = 0; m_buf = 0; m_word = '0; m_strb = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    // Good 64-byte frame: addresses 0..7, visible two cycles after tlast.
    do_reset(); idle(4);
    send_frame(64, 1'b0, 0);
    idle(1);
    check("f64_avail", 64'(rx_avail), 64'd1);
    check("f64_buf", 64'(rx_buf), 64'd0);
    check("f64_len", 64'(rx_len), 64'd64);
    pop_all();

    // 61-byte frame with gaps: partial final word.
    do_reset(); idle(4);
    send_frame(61, 1'b0, 20);
    idle(3);
    check("f61_len", 64'(rx_len), 64'd61);
    pop_all();

    // Bad frame: no commit, counted, buffer 0 reused next.
    do_reset(); idle(4);
    send_frame(40, 1'b1, 10);
    idle(3);
    check("bad_drop", 64'(drop_cnt), 64'd1);
    check("bad_avail", 64'(rx_avail), 64'd0);
    send_frame(20, 1'b0, 0);
    idle(3);
    check("bad_next_buf", 64'(rx_buf), 64'd0);
    pop_all();

    // Five frames without pops: the fifth finds the ring full.
    do_reset(); idle(4);
    for (int i = 0; i < 5; i++) begin
      send_frame(20 + i, 1'b0, 0);
      idle(1);
    end
    idle(3);
    check("full_drop", 64'(drop_cnt), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("full_pop_buf", 64'(rx_buf), 64'(k));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    check("full_empty", 64'(rx_avail), 64'd0);

    // Oversized frame: writes stop at the buffer end, then buffer 0 is reused.
    do_reset(); idle(4);
    send_frame(2049, 1'b0, 0);
    idle(2);
    check("big_drop", 64'(drop_cnt), 64'd1);
    send_frame(64, 1'b0, 0);
    idle(2);
    check("big_next_avail", 64'(rx_avail), 64'd1);
    check("big_next_buf", 64'(rx_buf), 64'd0);
    check("big_next_len", 64'(rx_len), 64'd64);
    pop_all();

    // Pop in the same cycle as a commit while one frame is held.
    do_reset(); idle(4);
    send_frame(20, 1'b0, 0);
    idle(3);
    send_frame(30, 1'b0, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("cp_avail", 64'(rx_avail), 64'd1);
    check("cp_buf", 64'(rx_buf), 64'd1);
    check("cp_len", 64'(rx_len), 64'd30);
    pop_all();

    // Reset mid-frame: the tail is skipped silently and nothing commits.
    do_reset(); idle(4);
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), i == 19, 1'b0, 1'b0);
    idle(3);
    check("mid_rst_avail", 64'(rx_avail), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    send_frame(40, 1'b0, 0);
    idle(3);
    check("mid_rst_buf", 64'(rx_buf), 64'd0);
    check("mid_rst_len", 64'(rx_len), 64'd40);
    pop_all();

    // Random traffic with alternating slow and fast software.
    do_reset(); idle(4);
    for (int f = 0; f < 150; f++) begin
      int r, len;
      pop_pct = ((f / 25) % 2 != 0) ? 5 : 60;
      r = int'($urandom_range(99));
      if (r < 4)       len = int'($urandom_range(2060, 2040));
      else if (r < 15) len = int'($urandom_range(16, 1));
      else             len = int'($urandom_range(120, 14));
      send_frame(len, $urandom_range(9) == 0, int'($urandom_range(30, 0)));
      idle(int'($urandom_range(3, 0)));
    end
    pop_pct = 100;
    idle(20);
    check("final_avail", 64'(rx_avail), 64'd0);
    check("writes_drained", 64'(wr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
